// File: rtl/tlb_pkg.sv
// tlb_pkg: shared constants and types for the TLB slice.
//   TLB_NUM  - default number of entries
//   IDX_W    - entry index width (log2 of TLB_NUM)
//   *_W      - field widths of a TLB entry
//   page_t   - the per-page {pfn, c, d, v} group
//   PAGE_W / ENTRY_W - widths of one page group and of a full read/write bundle
package tlb_pkg;
  localparam int TLB_NUM = 16;
  localparam int IDX_W   = 4;
  localparam int VPN2_W  = 19;
  localparam int ASID_W  = 8;
  localparam int PFN_W   = 20;
  localparam int C_W     = 3;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  localparam int PAGE_W  = PFN_W + C_W + 2;
  // vpn2 + asid + g + two page groups
  localparam int ENTRY_W = VPN2_W + ASID_W + 1 + 2 * PAGE_W;
endpackage

// File: rtl/tlb_if.sv
// tlb_if: bundles the two search ports, the write port and the read port.
//   master - drives lookups/writes/read index, receives results
//   slave  - the TLB itself
interface tlb_if;
  import tlb_pkg::*;

  // search port 0 (fetch) and 1 (data access / TLBP)
  logic [VPN2_W-1:0] s0_vpn2;
  logic              s0_odd_page;
  logic [ASID_W-1:0] s0_asid;
  logic              s0_found;
  logic [IDX_W-1:0]  s0_index;
  logic [PFN_W-1:0]  s0_pfn;
  logic [C_W-1:0]    s0_c;
  logic              s0_d;
  logic              s0_v;

  logic [VPN2_W-1:0] s1_vpn2;
  logic              s1_odd_page;
  logic [ASID_W-1:0] s1_asid;
  logic              s1_found;
  logic [IDX_W-1:0]  s1_index;
  logic [PFN_W-1:0]  s1_pfn;
  logic [C_W-1:0]    s1_c;
  logic              s1_d;
  logic              s1_v;

  // write port
  logic              we;
  logic [IDX_W-1:0]  w_index;
  logic [VPN2_W-1:0] w_vpn2;
  logic [ASID_W-1:0] w_asid;
  logic              w_g;
  logic [PFN_W-1:0]  w_pfn0;
  logic [C_W-1:0]    w_c0;
  logic              w_d0;
  logic              w_v0;
  logic [PFN_W-1:0]  w_pfn1;
  logic [C_W-1:0]    w_c1;
  logic              w_d1;
  logic              w_v1;

  // read port
  logic [IDX_W-1:0]  r_index;
  logic [VPN2_W-1:0] r_vpn2;
  logic [ASID_W-1:0] r_asid;
  logic              r_g;
  logic [PFN_W-1:0]  r_pfn0;
  logic [C_W-1:0]    r_c0;
  logic              r_d0;
  logic              r_v0;
  logic [PFN_W-1:0]  r_pfn1;
  logic [C_W-1:0]    r_c1;
  logic              r_d1;
  logic              r_v1;

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g,
    output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g,
    input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb_match.sv
// tlb_match: compares one lookup against every entry.
//   entry_vpn2/entry_asid/entry_g - stored tags of all entries
//   vpn2/asid                     - lookup key
//   match                         - one bit per matching entry
//   index                         - lowest-numbered matching entry (0 if none)
module tlb_match
  import tlb_pkg::*;
#(
  parameter int TLBNUM = TLB_NUM
) (
  input  logic [VPN2_W-1:0] entry_vpn2 [TLBNUM],
  input  logic [ASID_W-1:0] entry_asid [TLBNUM],
  input  logic [TLBNUM-1:0] entry_g,
  input  logic [VPN2_W-1:0] vpn2,
  input  logic [ASID_W-1:0] asid,
  output logic [TLBNUM-1:0] match,
  output logic [IDX_W-1:0]  index
);
  genvar gi;
  generate
    for (gi = 0; gi < TLBNUM; gi++) begin : g_cmp
      // global entries ignore the ASID
      assign match[gi] = (entry_vpn2[gi] == vpn2) &&
                         (entry_g[gi] || (entry_asid[gi] == asid));
    end
  endgenerate

  // Scanning downward lets the lowest matching entry overwrite any higher one.
  always_comb begin
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) index = i[IDX_W-1:0];
    end
  end
endmodule

// File: rtl/tlb.sv
// tlb: fully associative TLB with two combinational search ports, one write
// port and one combinational read port.
//   clk   - single clock, rising edge
//   reset - synchronous active-high, clears every entry (beats a same-cycle write)
//   bus   - tlb_if.slave: search ports s0/s1, write port w_*, read port r_*
// Searches and reads see pre-write contents during a write cycle.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM = TLB_NUM
) (
  input logic   clk,
  input logic   reset,
  tlb_if.slave  bus
);
  // per-field storage; page fields indexed [page][entry]
  logic [VPN2_W-1:0] vpn2_reg [TLBNUM];
  logic [ASID_W-1:0] asid_reg [TLBNUM];
  logic [TLBNUM-1:0] g_reg;
  logic [PFN_W-1:0]  pfn_reg  [2][TLBNUM];
  logic [C_W-1:0]    c_reg    [2][TLBNUM];
  logic              d_reg    [2][TLBNUM];
  logic              v_reg    [2][TLBNUM];

  always_ff @(posedge clk) begin
    if (reset) begin
      g_reg <= '0;
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_reg[i] <= '0;
        asid_reg[i] <= '0;
        for (int p = 0; p < 2; p++) begin
          pfn_reg[p][i] <= '0;
          c_reg[p][i]   <= '0;
          d_reg[p][i]   <= 1'b0;
          v_reg[p][i]   <= 1'b0;
        end
      end
    end else if (bus.we) begin
      vpn2_reg[bus.w_index]   <= bus.w_vpn2;
      asid_reg[bus.w_index]   <= bus.w_asid;
      g_reg[bus.w_index]      <= bus.w_g;
      pfn_reg[0][bus.w_index] <= bus.w_pfn0;
      c_reg[0][bus.w_index]   <= bus.w_c0;
      d_reg[0][bus.w_index]   <= bus.w_d0;
      v_reg[0][bus.w_index]   <= bus.w_v0;
      pfn_reg[1][bus.w_index] <= bus.w_pfn1;
      c_reg[1][bus.w_index]   <= bus.w_c1;
      d_reg[1][bus.w_index]   <= bus.w_d1;
      v_reg[1][bus.w_index]   <= bus.w_v1;
    end
  end

  // search port inputs gathered so both ports share one generate body
  logic [VPN2_W-1:0] s_vpn2 [2];
  logic              s_odd  [2];
  logic [ASID_W-1:0] s_asid [2];

  assign s_vpn2[0] = bus.s0_vpn2;
  assign s_odd[0]  = bus.s0_odd_page;
  assign s_asid[0] = bus.s0_asid;
  assign s_vpn2[1] = bus.s1_vpn2;
  assign s_odd[1]  = bus.s1_odd_page;
  assign s_asid[1] = bus.s1_asid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [TLBNUM-1:0] match;
      logic [IDX_W-1:0]  hit_index;
      logic              found;
      logic [IDX_W-1:0]  index;
      page_t             page;

      tlb_match #(.TLBNUM(TLBNUM)) u_match (
        .entry_vpn2 (vpn2_reg),
        .entry_asid (asid_reg),
        .entry_g    (g_reg),
        .vpn2       (s_vpn2[gi]),
        .asid       (s_asid[gi]),
        .match      (match),
        .index      (hit_index)
      );

      // a miss forces every result field to zero
      always_comb begin
        found = |match;
        index = '0;
        page  = '0;
        if (found) begin
          index    = hit_index;
          page.pfn = pfn_reg[s_odd[gi]][hit_index];
          page.c   = c_reg[s_odd[gi]][hit_index];
          page.d   = d_reg[s_odd[gi]][hit_index];
          page.v   = v_reg[s_odd[gi]][hit_index];
        end
      end
    end
  endgenerate

  assign bus.s0_found = g_port[0].found;
  assign bus.s0_index = g_port[0].index;
  assign bus.s0_pfn   = g_port[0].page.pfn;
  assign bus.s0_c     = g_port[0].page.c;
  assign bus.s0_d     = g_port[0].page.d;
  assign bus.s0_v     = g_port[0].page.v;

  assign bus.s1_found = g_port[1].found;
  assign bus.s1_index = g_port[1].index;
  assign bus.s1_pfn   = g_port[1].page.pfn;
  assign bus.s1_c     = g_port[1].page.c;
  assign bus.s1_d     = g_port[1].page.d;
  assign bus.s1_v     = g_port[1].page.v;

  assign bus.r_vpn2 = vpn2_reg[bus.r_index];
  assign bus.r_asid = asid_reg[bus.r_index];
  assign bus.r_g    = g_reg[bus.r_index];
  assign bus.r_pfn0 = pfn_reg[0][bus.r_index];
  assign bus.r_c0   = c_reg[0][bus.r_index];
  assign bus.r_d0   = d_reg[0][bus.r_index];
  assign bus.r_v0   = v_reg[0][bus.r_index];
  assign bus.r_pfn1 = pfn_reg[1][bus.r_index];
  assign bus.r_c1   = c_reg[1][bus.r_index];
  assign bus.r_d1   = d_reg[1][bus.r_index];
  assign bus.r_v1   = v_reg[1][bus.r_index];
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: self-checking bench for tlb. Directed search vectors held in a
// table, hand-written multi-cycle sequences for write/search overlap and
// reset-vs-write, then randomized traffic against a reference model.
module tb_tlb;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_if bus ();

  tlb #(.TLBNUM(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } sres_t;

  typedef struct {
    string       name;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    sres_t       exp;
  } vec_t;

  ent_t  model [16];
  vec_t  vq [$];
  int    n_total = 0;
  int    n_pass  = 0;

  // ---------------- reference model ----------------
  function automatic sres_t ref_search(logic [18:0] vpn2, logic odd, logic [7:0] asid);
    sres_t r = '0;
    for (int i = 0; i < 16; i++) begin
      if (model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) begin
        r.found = 1'b1;
        r.index = 4'(i);
        r.pfn   = odd ? model[i].pfn1 : model[i].pfn0;
        r.c     = odd ? model[i].c1   : model[i].c0;
        r.d     = odd ? model[i].d1   : model[i].d0;
        r.v     = odd ? model[i].v1   : model[i].v0;
        break;
      end
    end
    return r;
  endfunction

  function automatic sres_t act_search(int p);
    sres_t r;
    if (p == 0) r = {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v};
    else        r = {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v};
    return r;
  endfunction

  function automatic ent_t act_read();
    ent_t r;
    r = {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
         bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1};
    return r;
  endfunction

  function automatic vec_t mk(string name, logic [18:0] vpn2, logic odd, logic [7:0] asid,
                              logic f, logic [3:0] idx, logic [19:0] pfn,
                              logic [2:0] c, logic d, logic v);
    vec_t t;
    t.name = name; t.vpn2 = vpn2; t.odd = odd; t.asid = asid;
    t.exp = {f, idx, pfn, c, d, v};
    return t;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_s(string name, int p, sres_t exp);
    sres_t a = act_search(p);
    n_total++;
    if (a === exp) begin
      n_pass++;
      $display("ok   %s s%0d found=%0d idx=%0d pfn=%h c=%0d d=%0d v=%0d",
               name, p, a.found, a.index, a.pfn, a.c, a.d, a.v);
    end else begin
      $display("FAIL %s s%0d got found=%0d idx=%0d pfn=%h c=%0d d=%0d v=%0d, want found=%0d idx=%0d pfn=%h c=%0d d=%0d v=%0d",
               name, p, a.found, a.index, a.pfn, a.c, a.d, a.v,
               exp.found, exp.index, exp.pfn, exp.c, exp.d, exp.v);
    end
  endtask

  task automatic chk_r(string name, ent_t exp);
    ent_t a = act_read();
    n_total++;
    if (a === exp) begin
      n_pass++;
      $display("ok   %s r_index=%0d entry=%h", name, bus.r_index, a);
    end else begin
      $display("FAIL %s r_index=%0d got entry=%h, want %h", name, bus.r_index, a, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_write(logic [3:0] idx, ent_t e);
    bus.we = 1'b1; bus.w_index = idx;
    bus.w_vpn2 = e.vpn2; bus.w_asid = e.asid; bus.w_g = e.g;
    bus.w_pfn0 = e.pfn0; bus.w_c0 = e.c0; bus.w_d0 = e.d0; bus.w_v0 = e.v0;
    bus.w_pfn1 = e.pfn1; bus.w_c1 = e.c1; bus.w_d1 = e.d1; bus.w_v1 = e.v1;
  endtask

  task automatic do_write(logic [3:0] idx, ent_t e);
    @(negedge clk);
    drive_write(idx, e);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    model[idx] = e;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // apply every queued vector to both search ports, then empty the table
  task automatic run_vecs();
    foreach (vq[k]) begin
      bus.s0_vpn2 = vq[k].vpn2; bus.s0_odd_page = vq[k].odd; bus.s0_asid = vq[k].asid;
      bus.s1_vpn2 = vq[k].vpn2; bus.s1_odd_page = vq[k].odd; bus.s1_asid = vq[k].asid;
      #1;
      chk_s(vq[k].name, 0, vq[k].exp);
      chk_s(vq[k].name, 1, vq[k].exp);
    end
    vq.delete();
  endtask

  // ---------------- test ----------------
  ent_t e5, e3, e9, e7, e2;
  ent_t wr;

  initial begin
    reset = 1'b1;
    drive_write(4'd0, '0);
    bus.we = 1'b0;
    bus.s0_vpn2 = '0; bus.s0_odd_page = 1'b0; bus.s0_asid = '0;
    bus.s1_vpn2 = '0; bus.s1_odd_page = 1'b0; bus.s1_asid = '0;
    bus.r_index = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // after reset every entry is all-zero: vpn2=0/asid=0 hits entry 0, invalid
    vq.push_back(mk("rst_hit_even", 19'h00000, 1'b0, 8'h00, 1'b1, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk("rst_hit_odd",  19'h00000, 1'b1, 8'h00, 1'b1, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk("rst_miss",     19'h12345, 1'b0, 8'h00, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    run_vecs();
    bus.r_index = 4'd9; #1;
    chk_r("rst_read9", '0);

    e5 = '{vpn2:19'h00400, asid:8'h11, g:1'b0, pfn0:20'h01000, c0:3'd0, d0:1'b0, v0:1'b1,
           pfn1:20'h01001, c1:3'd0, d1:1'b1, v1:1'b1};
    do_write(4'd5, e5);
    vq.push_back(mk("w5_odd",       19'h00400, 1'b1, 8'h11, 1'b1, 4'd5, 20'h01001, 3'd0, 1'b1, 1'b1));
    vq.push_back(mk("w5_even",      19'h00400, 1'b0, 8'h11, 1'b1, 4'd5, 20'h01000, 3'd0, 1'b0, 1'b1));
    vq.push_back(mk("w5_asid_miss", 19'h00400, 1'b1, 8'h22, 1'b0, 4'd0, 20'h0,     3'd0, 1'b0, 1'b0));
    run_vecs();
    bus.r_index = 4'd5; #1;
    chk_r("w5_read", e5);

    e5.g = 1'b1;
    do_write(4'd5, e5);
    vq.push_back(mk("w5_global", 19'h00400, 1'b1, 8'h22, 1'b1, 4'd5, 20'h01001, 3'd0, 1'b1, 1'b1));
    run_vecs();

    e3 = '{vpn2:19'h0abcd, asid:8'h33, g:1'b0, pfn0:20'h00333, c0:3'd3, d0:1'b0, v0:1'b1,
           pfn1:20'h10333, c1:3'd5, d1:1'b1, v1:1'b0};
    e9 = '{vpn2:19'h0abcd, asid:8'h33, g:1'b0, pfn0:20'h00999, c0:3'd2, d0:1'b1, v0:1'b1,
           pfn1:20'h10999, c1:3'd6, d1:1'b0, v1:1'b1};
    do_write(4'd9, e9);
    do_write(4'd3, e3);
    vq.push_back(mk("dup_lowest_even", 19'h0abcd, 1'b0, 8'h33, 1'b1, 4'd3, 20'h00333, 3'd3, 1'b0, 1'b1));
    vq.push_back(mk("dup_lowest_odd",  19'h0abcd, 1'b1, 8'h33, 1'b1, 4'd3, 20'h10333, 3'd5, 1'b1, 1'b0));
    run_vecs();
    e3.vpn2 = 19'h0abce;
    do_write(4'd3, e3);
    vq.push_back(mk("dup_inval_even", 19'h0abcd, 1'b0, 8'h33, 1'b1, 4'd9, 20'h00999, 3'd2, 1'b1, 1'b1));
    vq.push_back(mk("dup_inval_odd",  19'h0abcd, 1'b1, 8'h33, 1'b1, 4'd9, 20'h10999, 3'd6, 1'b0, 1'b1));
    vq.push_back(mk("moved_entry3",   19'h0abce, 1'b0, 8'h33, 1'b1, 4'd3, 20'h00333, 3'd3, 1'b0, 1'b1));
    run_vecs();

    // write to 7 while s1 and the read port look at it in the same cycle
    e7 = '{vpn2:19'h07777, asid:8'h44, g:1'b0, pfn0:20'h07000, c0:3'd1, d0:1'b1, v0:1'b1,
           pfn1:20'h07001, c1:3'd4, d1:1'b0, v1:1'b1};
    @(negedge clk);
    drive_write(4'd7, e7);
    bus.s1_vpn2 = 19'h07777; bus.s1_odd_page = 1'b0; bus.s1_asid = 8'h44;
    bus.r_index = 4'd7;
    #1;
    chk_s("wr_same_cycle", 1, '0);
    chk_r("wr_same_cycle_read_old", '0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    model[7] = e7;
    #1;
    chk_s("wr_next_cycle", 1, {1'b1, 4'd7, 20'h07000, 3'd1, 1'b1, 1'b1});
    chk_r("wr_next_cycle_read_new", e7);

    // reset wins over a simultaneous write to entry 2
    e2 = '{vpn2:19'h02222, asid:8'h55, g:1'b1, pfn0:20'h02000, c0:3'd7, d0:1'b1, v0:1'b1,
           pfn1:20'h02001, c1:3'd7, d1:1'b1, v1:1'b1};
    @(negedge clk);
    reset = 1'b1;
    drive_write(4'd2, e2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.we = 1'b0;
    clear_model();
    bus.r_index = 4'd2; #1;
    chk_r("rst_vs_we_read2", '0);
    bus.r_index = 4'd7; #1;
    chk_r("rst_cleared_read7", '0);
    vq.push_back(mk("rst_cleared_search", 19'h07777, 1'b0, 8'h44, 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0));
    run_vecs();

    // randomized traffic: small vpn2/asid pools so hits and duplicates are common
    for (int cyc = 0; cyc < 250; cyc++) begin
      logic do_we;
      @(negedge clk);
      do_we = ($urandom_range(0, 2) == 0);
      wr = '{vpn2:19'($urandom_range(0, 3)), asid:8'($urandom_range(0, 3)), g:1'($urandom_range(0, 1)),
             pfn0:20'($urandom), c0:3'($urandom), d0:1'($urandom), v0:1'($urandom),
             pfn1:20'($urandom), c1:3'($urandom), d1:1'($urandom), v1:1'($urandom)};
      drive_write(4'($urandom_range(0, 15)), wr);
      bus.we = do_we;
      bus.s0_vpn2 = 19'($urandom_range(0, 3)); bus.s0_odd_page = 1'($urandom); bus.s0_asid = 8'($urandom_range(0, 3));
      bus.s1_vpn2 = 19'($urandom_range(0, 3)); bus.s1_odd_page = 1'($urandom); bus.s1_asid = 8'($urandom_range(0, 3));
      bus.r_index = 4'($urandom_range(0, 15));
      #1;
      chk_s($sformatf("rnd%0d", cyc), 0, ref_search(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid));
      chk_s($sformatf("rnd%0d", cyc), 1, ref_search(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid));
      chk_r($sformatf("rnd%0d", cyc), model[bus.r_index]);
      @(posedge clk);
      #1;
      if (do_we) model[bus.w_index] = wr;
      bus.we = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries; index width is log2(TLBNUM) = 4.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have search port 0 inputs: s0_vpn2 19 (VA[31:13]), s0_odd_page 1 (VA[12]), s0_asid 8.
REQ-005 SHALL have search port 0 outputs: s0_found 1, s0_index 4, s0_pfn 20, s0_c 3, s0_d 1, s0_v 1.
REQ-006 SHALL have search port 1, identical to port 0 under the s1_ prefix; port 1 serves data access and TLBP.
REQ-007 SHALL have write port inputs: we 1, w_index 4, w_vpn2 19, w_asid 8, w_g 1, w_pfn0 20, w_c0 3, w_d0 1, w_v0 1, w_pfn1 20, w_c1 3, w_d1 1, w_v1 1.
REQ-008 SHALL have read port input r_index 4.
REQ-009 SHALL have read port outputs: r_vpn2 19, r_asid 8, r_g 1, r_pfn0 20, r_c0 3, r_d0 1, r_v0 1, r_pfn1 20, r_c1 3, r_d1 1, r_v1 1.

Function
REQ-010 SHALL store per entry: vpn2, asid, g, and {pfn,c,d,v} for page 0 (even) and page 1 (odd).
REQ-011 SHALL write all fields of entry w_index at the rising clk edge when we=1.
REQ-012 SHALL not change any entry when we=0.
REQ-013 SHALL declare entry i matched on a port when vpn2[i]==sX_vpn2 and (g[i]==1 or asid[i]==sX_asid).
REQ-014 SHALL drive sX_found = OR of all match bits; search is combinational, zero-cycle latency.
REQ-015 SHALL resolve multiple matches to the lowest-numbered matching entry for sX_index and the page outputs.
REQ-016 SHALL select page-1 fields when sX_odd_page=1 and page-0 fields otherwise.
REQ-017 SHALL drive sX_index, sX_pfn, sX_c, sX_d, sX_v to 0 when sX_found=0.
REQ-018 SHALL provide the contents of entry r_index combinationally on r_*.
REQ-019 SHALL have search and read in a write cycle return pre-write contents; new contents are visible from the next cycle (no bypass).
REQ-020 SHALL evaluate both search ports and the read port independently in the same cycle with no interaction.
REQ-021 SHALL have no handshake: the write is accepted unconditionally every cycle that we=1.

Reset
REQ-022 SHALL clear every field of every entry to 0 when reset=1 at a rising edge.
REQ-023 SHALL give reset priority over a simultaneous we=1, so the write is discarded.
REQ-024 SHALL, after reset, report found=1, index=0, v=0 for a search with vpn2=0 and asid=0; this is the intended behaviour (TLB-invalid, not refill).
REQ-025 SHALL have all outputs derive combinationally from stored state and inputs; there are no separate output registers to reset.

Structure
REQ-026 SHALL place TLBNUM, the field widths (VPN2 19, ASID 8, PFN 20, C 3) and the read/write bundle widths in the shared mycpu.h constants.
REQ-027 SHALL have one natural sub-module, tlb_match, instantiated once per search port; it produces the match vector and a priority-encoded index.
REQ-028 SHALL have storage as flat per-field register arrays indexed by entry; no memory macro.

Verification
REQ-029 SHALL verify: reset, then s0 search vpn2=0x00000, asid=0 -> found=1, index=0, v=0; vpn2=0x12345 -> found=0, all outputs 0.
REQ-030 SHALL verify: write idx 5 {vpn2=0x00400, asid=0x11, g=0, pfn0=0x01000, v0=1, pfn1=0x01001, d1=1, v1=1}, then search asid=0x11 odd=1 -> found=1, index=5, pfn=0x01001, d=1; asid=0x22 -> found=0.
REQ-031 SHALL verify: the same entry rewritten with g=1 -> an asid=0x22 search hits with index=5.
REQ-032 SHALL verify: entries 3 and 9 written with an identical vpn2/asid -> both ports report index=3; invalidate entry 3 (vpn2 changed) -> index=9.
REQ-033 SHALL verify: we=1 to idx 7 while s1 searches the new vpn2 in the same cycle -> found=0 that cycle, found=1 and index=7 next cycle; r_index=7 shows old then new data.
REQ-034 SHALL verify: reset asserted together with we=1 to idx 2 -> the entry 2 read returns all zeros afterwards.
